// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4 master port between instruction fetch (IF) and load/store (LS),
// one single-beat transaction at a time. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    CCLK,
    input  logic                    CRST,
    input  logic                    IF_REQ,
    input  logic [ADDR_WIDTH-1:0]   IF_ADDR,
    output logic [DATA_WIDTH-1:0]   IF_RDATA,
    output logic                    IF_ACK,
    input  logic                    LS_REQ,
    input  logic                    LS_WE,
    input  logic [ADDR_WIDTH-1:0]   LS_ADDR,
    input  logic [DATA_WIDTH-1:0]   LS_WDATA,
    input  logic [DATA_WIDTH/8-1:0] LS_WSTRB,
    output logic [DATA_WIDTH-1:0]   LS_RDATA,
    output logic                    LS_ACK,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RLAST,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic                    BUSY,
    output logic                    ERR,
    output logic [2:0]              DBG_STATE
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

    state_t                state;
    logic                  gnt_ls;
    logic                  pick_ls;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic                  aw_ok;
    logic                  w_ok;
    logic                  unused_bits;

`ifdef MEM_ARB_RR_EN
    logic last_ls;
    // On contention the requester that was not granted last time wins.
    assign pick_ls = LS_REQ && !(IF_REQ && last_ls);
`else
    assign pick_ls = LS_REQ;
`endif

    assign pick_addr = pick_ls ? {LS_ADDR[ADDR_WIDTH-1:2], 2'b00}
                               : {IF_ADDR[ADDR_WIDTH-1:2], 2'b00};
    // A write channel counts as done once its VALID has already dropped or handshakes now.
    assign aw_ok       = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_ok        = !M_AXI_WVALID || M_AXI_WREADY;
    assign DBG_STATE   = state;
    // Single-beat reads make RLAST meaningless; word alignment drops the low address bits.
    assign unused_bits = ^{M_AXI_RLAST, IF_ADDR[1:0], LS_ADDR[1:0]};

    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            state         <= IDLE;
            gnt_ls        <= 1'b0;
            IF_RDATA      <= '0;
            IF_ACK        <= 1'b0;
            LS_RDATA      <= '0;
            LS_ACK        <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WLAST   <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            BUSY          <= 1'b0;
            ERR           <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_ls       <= 1'b1;
`endif
        end else begin
            IF_ACK <= 1'b0;
            LS_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (IF_REQ || LS_REQ) begin
                        gnt_ls <= pick_ls;
                        BUSY   <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_ls <= pick_ls;
`endif
                        if (pick_ls && LS_WE) begin
                            state         <= WR_AW;
                            M_AXI_AWADDR  <= pick_addr;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WDATA   <= LS_WDATA;
                            M_AXI_WSTRB   <= LS_WSTRB;
                            M_AXI_WLAST   <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= RD_A;
                            M_AXI_ARADDR  <= pick_addr;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_D;
                    end
                end
                RD_D: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (M_AXI_RRESP != 2'b00) ERR <= 1'b1;
                        if (gnt_ls) begin
                            LS_RDATA <= M_AXI_RDATA;
                            LS_ACK   <= 1'b1;
                        end else begin
                            IF_RDATA <= M_AXI_RDATA;
                            IF_ACK   <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                WR_AW: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                        M_AXI_WLAST  <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) ERR <= 1'b1;
                        LS_ACK <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
    logic        CCLK = 1'b0;
    logic        CRST;
    logic        IF_REQ, LS_REQ, LS_WE;
    logic [31:0] IF_ADDR, LS_ADDR, LS_WDATA;
    logic [3:0]  LS_WSTRB;
    logic [31:0] IF_RDATA, LS_RDATA;
    logic        IF_ACK, LS_ACK;
    logic [31:0] M_AXI_ARADDR, M_AXI_RDATA, M_AXI_AWADDR, M_AXI_WDATA;
    logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]  M_AXI_RRESP, M_AXI_BRESP;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic        BUSY, ERR;
    logic [2:0]  DBG_STATE;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CCLK(CCLK), .CRST(CRST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_ACK(IF_ACK),
        .LS_REQ(LS_REQ), .LS_WE(LS_WE), .LS_ADDR(LS_ADDR), .LS_WDATA(LS_WDATA),
        .LS_WSTRB(LS_WSTRB), .LS_RDATA(LS_RDATA), .LS_ACK(LS_ACK),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .BUSY(BUSY), .ERR(ERR), .DBG_STATE(DBG_STATE)
    );

    always #5 CCLK = ~CCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic slave_ready(input logic rvalid, input logic [31:0] rdata,
                               input logic [1:0] rresp, input logic [1:0] bresp);
        M_AXI_ARREADY = 1'b1;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_RVALID  = rvalid;
        M_AXI_RDATA   = rdata;
        M_AXI_RRESP   = rresp;
        M_AXI_RLAST   = 1'b1;
        M_AXI_BVALID  = 1'b1;
        M_AXI_BRESP   = bresp;
    endtask

    task automatic wait_for_ack(output int n, output logic got_if, output logic got_ls);
        n = 0;
        got_if = 1'b0;
        got_ls = 1'b0;
        while (!(got_if || got_ls) && n < 30) begin
            @(negedge CCLK);
            n++;
            got_if = IF_ACK;
            got_ls = LS_ACK;
        end
    endtask

    task automatic test_reset();
        CRST = 1'b1;
        IF_REQ = 0; LS_REQ = 0; LS_WE = 0; IF_ADDR = '0; LS_ADDR = '0; LS_WDATA = '0; LS_WSTRB = '0;
        M_AXI_ARREADY = 0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 0; M_AXI_RVALID = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BRESP = '0; M_AXI_BVALID = 0;
        repeat (2) @(negedge CCLK);
        checks++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshake: ar=%b r=%b aw=%b w=%b wl=%b b=%b expected all 0",
                     M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY);
        end
        checks++;
        if ({M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== 100'b0) begin
            errors++;
            $display("FAIL reset_addr_data: araddr=%h awaddr=%h wdata=%h wstrb=%h expected 0",
                     M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
        checks++;
        if ({IF_ACK, LS_ACK, BUSY, ERR} !== 4'b0 || IF_RDATA !== 32'h0 || LS_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: if_ack=%b ls_ack=%b busy=%b err=%b if_rdata=%h ls_rdata=%h expected 0",
                     IF_ACK, LS_ACK, BUSY, ERR, IF_RDATA, LS_RDATA);
        end
        CRST = 1'b0;
        @(negedge CCLK);
        checks++;
        if (BUSY !== 1'b0 || DBG_STATE !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b state=%0d expected 0 0", BUSY, DBG_STATE);
        end
    endtask

    task automatic test_if_read();
        M_AXI_ARREADY = 1'b1;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RRESP   = 2'b00;
        IF_ADDR = 32'h0000_0104;
        IF_REQ  = 1'b1;
        @(negedge CCLK);
        checks++;
        if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h0000_0104 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL if_read_ar: arvalid=%b araddr=%h busy=%b expected 1 00000104 1",
                     M_AXI_ARVALID, M_AXI_ARADDR, BUSY);
        end
        @(negedge CCLK);
        checks++;
        if (M_AXI_RREADY !== 1'b1 || M_AXI_ARVALID !== 1'b0 || IF_ACK !== 1'b0) begin
            errors++;
            $display("FAIL if_read_r: rready=%b arvalid=%b if_ack=%b expected 1 0 0",
                     M_AXI_RREADY, M_AXI_ARVALID, IF_ACK);
        end
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'hDEAD_BEEF;
        @(negedge CCLK);
        M_AXI_RVALID = 1'b0;
        checks++;
        if (IF_ACK !== 1'b1 || IF_RDATA !== 32'hDEAD_BEEF || LS_ACK !== 1'b0 || M_AXI_RREADY !== 1'b0) begin
            errors++;
            $display("FAIL if_read_ack: if_ack=%b if_rdata=%h ls_ack=%b rready=%b expected 1 deadbeef 0 0",
                     IF_ACK, IF_RDATA, LS_ACK, M_AXI_RREADY);
        end
        @(negedge CCLK);
        IF_REQ = 1'b0;
        checks++;
        if (IF_ACK !== 1'b0 || BUSY !== 1'b0 || DBG_STATE !== 3'd0) begin
            errors++;
            $display("FAIL if_read_idle: if_ack=%b busy=%b state=%0d expected 0 0 0", IF_ACK, BUSY, DBG_STATE);
        end
    endtask

    task automatic test_ls_store();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BVALID  = 1'b0;
        LS_ADDR = 32'h1000_0002; LS_WDATA = 32'h1234_5678; LS_WSTRB = 4'b1100;
        LS_WE = 1'b1; LS_REQ = 1'b1;
        @(negedge CCLK);
        checks++;
        if (M_AXI_AWVALID !== 1'b1 || M_AXI_WVALID !== 1'b1 || M_AXI_WLAST !== 1'b1 ||
            M_AXI_AWADDR !== 32'h1000_0000 || M_AXI_WDATA !== 32'h1234_5678 || M_AXI_WSTRB !== 4'b1100) begin
            errors++;
            $display("FAIL store_aw_w: awv=%b wv=%b wlast=%b awaddr=%h wdata=%h wstrb=%b expected 1 1 1 10000000 12345678 1100",
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
        @(negedge CCLK);
        checks++;
        if (M_AXI_WVALID !== 1'b0 || M_AXI_AWVALID !== 1'b1 || M_AXI_BREADY !== 1'b0) begin
            errors++;
            $display("FAIL store_w_drop: wv=%b awv=%b bready=%b expected 0 1 0", M_AXI_WVALID, M_AXI_AWVALID, M_AXI_BREADY);
        end
        @(negedge CCLK);
        checks++;
        if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 32'h1000_0000) begin
            errors++;
            $display("FAIL store_aw_hold: awv=%b awaddr=%h expected 1 10000000", M_AXI_AWVALID, M_AXI_AWADDR);
        end
        M_AXI_AWREADY = 1'b1;
        @(negedge CCLK);
        M_AXI_AWREADY = 1'b0;
        checks++;
        if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0 || M_AXI_BREADY !== 1'b1 || LS_ACK !== 1'b0) begin
            errors++;
            $display("FAIL store_wr_b: awv=%b wv=%b bready=%b ls_ack=%b expected 0 0 1 0",
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, LS_ACK);
        end
        @(negedge CCLK);
        checks++;
        if (LS_ACK !== 1'b0 || M_AXI_BREADY !== 1'b1) begin
            errors++;
            $display("FAIL store_wait_b: ls_ack=%b bready=%b expected 0 1", LS_ACK, M_AXI_BREADY);
        end
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = 2'b00;
        @(negedge CCLK);
        M_AXI_BVALID = 1'b0;
        checks++;
        if (LS_ACK !== 1'b1 || IF_ACK !== 1'b0 || IF_RDATA !== 32'hDEAD_BEEF || M_AXI_BREADY !== 1'b0) begin
            errors++;
            $display("FAIL store_ack: ls_ack=%b if_ack=%b if_rdata=%h bready=%b expected 1 0 deadbeef 0",
                     LS_ACK, IF_ACK, IF_RDATA, M_AXI_BREADY);
        end
        @(negedge CCLK);
        LS_REQ = 1'b0;
        LS_WE  = 1'b0;
        checks++;
        if (LS_ACK !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL store_idle: ls_ack=%b busy=%b err=%b expected 0 0 0", LS_ACK, BUSY, ERR);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        int cyc;
        int acks;
        int last_ack_cyc;
`ifdef MEM_ARB_RR_EN
        exp_q = {32'h200, 32'h300, 32'h200, 32'h300, 32'h200, 32'h300};
`else
        exp_q = {32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h200};
`endif
        slave_ready(1'b1, 32'h5555_AAAA, 2'b00, 2'b00);
        IF_ADDR = 32'h0000_0200;
        LS_ADDR = 32'h0000_0300;
        LS_WE = 1'b0;
        IF_REQ = 1'b1;
        LS_REQ = 1'b1;
        cyc = 0; acks = 0; last_ack_cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(negedge CCLK);
            cyc++;
            if (IF_ACK || LS_ACK) begin
                exp = exp_q.pop_front();
                checks++;
                if (M_AXI_ARADDR !== exp || LS_ACK !== (exp == 32'h300) || IF_ACK !== (exp == 32'h200) ||
                    (LS_ACK && LS_RDATA !== 32'h5555_AAAA) || (IF_ACK && IF_RDATA !== 32'h5555_AAAA)) begin
                    errors++;
                    $display("FAIL arb_cont[%0d]: araddr=%h if_ack=%b ls_ack=%b expected winner %h",
                             acks, M_AXI_ARADDR, IF_ACK, LS_ACK, exp);
                end
                acks++;
                last_ack_cyc = cyc;
            end
        end
        checks++;
        if (acks !== 4 || last_ack_cyc !== 15) begin
            errors++;
            $display("FAIL arb_cont_timing: acks=%0d last_ack_cycle=%0d expected 4 15", acks, last_ack_cyc);
        end
        IF_REQ = 1'b0;
        LS_REQ = 1'b0;
        @(negedge CCLK);
        IF_REQ = 1'b1;
        LS_REQ = 1'b1;
        cyc = 0; acks = 0; last_ack_cyc = 0;
        while (acks < 2 && cyc < 20) begin
            @(negedge CCLK);
            cyc++;
            if (IF_ACK || LS_ACK) begin
                exp = exp_q.pop_front();
                checks++;
                if (M_AXI_ARADDR !== exp || LS_ACK !== (exp == 32'h300) || IF_ACK !== (exp == 32'h200)) begin
                    errors++;
                    $display("FAIL arb_pair[%0d]: araddr=%h if_ack=%b ls_ack=%b expected winner %h",
                             acks, M_AXI_ARADDR, IF_ACK, LS_ACK, exp);
                end
                if (IF_ACK) IF_REQ = 1'b0;
                if (LS_ACK) LS_REQ = 1'b0;
                acks++;
                last_ack_cyc = cyc;
            end
        end
        checks++;
        if (acks !== 2 || last_ack_cyc !== 7) begin
            errors++;
            $display("FAIL arb_pair_timing: acks=%0d last_ack_cycle=%0d expected 2 7", acks, last_ack_cyc);
        end
        IF_REQ = 1'b0;
        LS_REQ = 1'b0;
        @(negedge CCLK);
    endtask

    task automatic test_error_sticky();
        int n;
        logic got_if, got_ls;
        slave_ready(1'b1, 32'h0, 2'b00, 2'b00);
        LS_ADDR = 32'h2000_0010; LS_WDATA = 32'hCAFE_0001; LS_WSTRB = 4'hF;
        LS_WE = 1'b1; LS_REQ = 1'b1;
        wait_for_ack(n, got_if, got_ls);
        LS_REQ = 1'b0;
        checks++;
        if (n !== 3 || got_ls !== 1'b1 || got_if !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_store_ok: latency=%0d ls_ack=%b if_ack=%b err=%b expected 3 1 0 0", n, got_ls, got_if, ERR);
        end
        @(negedge CCLK);
        slave_ready(1'b1, 32'hBAD0_0001, 2'b10, 2'b00);
        LS_ADDR = 32'h2000_0008; LS_WE = 1'b0; LS_REQ = 1'b1;
        wait_for_ack(n, got_if, got_ls);
        LS_REQ = 1'b0;
        checks++;
        if (n !== 3 || got_ls !== 1'b1 || LS_RDATA !== 32'hBAD0_0001 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_load_slverr: latency=%0d ls_ack=%b ls_rdata=%h err=%b expected 3 1 bad00001 1",
                     n, got_ls, LS_RDATA, ERR);
        end
        @(negedge CCLK);
        slave_ready(1'b1, 32'h0000_0013, 2'b00, 2'b00);
        IF_ADDR = 32'h0000_0108; IF_REQ = 1'b1;
        wait_for_ack(n, got_if, got_ls);
        IF_REQ = 1'b0;
        checks++;
        if (n !== 3 || got_if !== 1'b1 || IF_RDATA !== 32'h0000_0013 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: latency=%0d if_ack=%b if_rdata=%h err=%b expected 3 1 00000013 1",
                     n, got_if, IF_RDATA, ERR);
        end
        @(negedge CCLK);
    endtask

    task automatic test_reset_mid();
        int n;
        logic got_if, got_ls;
        slave_ready(1'b0, 32'h0, 2'b00, 2'b00);
        M_AXI_BVALID = 1'b0;
        IF_ADDR = 32'h0000_0400; IF_REQ = 1'b1;
        @(negedge CCLK);
        @(negedge CCLK);
        checks++;
        if (M_AXI_RREADY !== 1'b1 || DBG_STATE !== 3'd2) begin
            errors++;
            $display("FAIL mid_rd_d: rready=%b state=%0d expected 1 2", M_AXI_RREADY, DBG_STATE);
        end
        CRST = 1'b1;
        @(negedge CCLK);
        checks++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, BUSY, ERR, IF_ACK, LS_ACK} !== 9'b0 ||
            IF_RDATA !== 32'h0 || DBG_STATE !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: ar=%b r=%b aw=%b w=%b b=%b busy=%b err=%b if_ack=%b if_rdata=%h state=%0d expected all 0",
                     M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, BUSY, ERR, IF_ACK,
                     IF_RDATA, DBG_STATE);
        end
        CRST = 1'b0;
        IF_ADDR = 32'h0000_0500;
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA = 32'h1357_9BDF;
        wait_for_ack(n, got_if, got_ls);
        IF_REQ = 1'b0;
        checks++;
        if (n !== 3 || got_if !== 1'b1 || got_ls !== 1'b0 || IF_RDATA !== 32'h1357_9BDF || M_AXI_ARADDR !== 32'h0000_0500) begin
            errors++;
            $display("FAIL mid_recover: latency=%0d if_ack=%b ls_ack=%b if_rdata=%h araddr=%h expected 3 1 0 13579bdf 00000500",
                     n, got_if, got_ls, IF_RDATA, M_AXI_ARADDR);
        end
        @(negedge CCLK);
        slave_ready(1'b0, 32'h0, 2'b00, 2'b10);
        LS_ADDR = 32'h3000_0004; LS_WDATA = 32'h0F0F_0F0F; LS_WSTRB = 4'b0011;
        LS_WE = 1'b1; LS_REQ = 1'b1;
        wait_for_ack(n, got_if, got_ls);
        LS_REQ = 1'b0;
        LS_WE = 1'b0;
        checks++;
        if (n !== 3 || got_ls !== 1'b1 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL mid_bresp_err: latency=%0d ls_ack=%b err=%b expected 3 1 1", n, got_ls, ERR);
        end
        @(negedge CCLK);
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_ls_store();
        test_arbitration();
        test_error_sticky();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
